// File: rtl/bram0_stream_loader_pkg.sv
// Shared constants for the BRAM0 stream loader and its accessor: geometry, lanes, state codes.
package bram0_stream_loader_pkg;

   localparam int unsigned DWIDTH        = 32;
   localparam int unsigned IN_DATA_WIDTH = 8;
   localparam int unsigned LANES         = DWIDTH / IN_DATA_WIDTH;
   localparam int unsigned LANE_W        = $clog2(LANES);
   localparam int unsigned AWIDTH        = 8;
   localparam int unsigned MEM_SIZE      = 256;
   localparam int unsigned CNT_BIT       = 31;

   localparam int unsigned STATE_W       = 3;

   localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
   localparam logic [STATE_W-1:0] S_FILL = 3'd1;
   localparam logic [STATE_W-1:0] S_KICK = 3'd2;
   localparam logic [STATE_W-1:0] S_WAIT = 3'd3;
   localparam logic [STATE_W-1:0] S_DONE = 3'd4;

endpackage

// File: rtl/bram0_stream_loader_if.sv
// Byte-stream valid/ready handshake feeding the BRAM0 loader.
interface bram0_stream_loader_if;
   import bram0_stream_loader_pkg::*;

   logic                     s_valid_i;
   logic [IN_DATA_WIDTH-1:0] s_data_i;
   logic                     s_last_i;
   logic                     s_ready_o;

   modport master (
      output s_valid_i,
      output s_data_i,
      output s_last_i,
      input  s_ready_o
   );

   modport slave (
      input  s_valid_i,
      input  s_data_i,
      input  s_last_i,
      output s_ready_o
   );

endinterface

// File: rtl/bram0_stream_loader_stream_packer.sv
// Packs accepted stream bytes into a BRAM0 row; lane 0 takes the first byte of each row.
module bram0_stream_loader_stream_packer
   import bram0_stream_loader_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     accept,
   input  logic [IN_DATA_WIDTH-1:0] data,
   input  logic                     last,
   output logic                     row_complete_c,
   output logic                     row_last_c,
   output logic [DWIDTH-1:0]        row_data_c
);

   logic [LANE_W-1:0] lane_q;
   logic [DWIDTH-1:0] pack_q;

   // Merge the incoming byte into its lane; lanes not yet filled read as zero.
   always_comb begin
      row_data_c = pack_q;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (lane_q == LANE_W'(k)) begin
            row_data_c[k*IN_DATA_WIDTH +: IN_DATA_WIDTH] = data;
         end
      end
      row_complete_c = accept && ((lane_q == LANE_W'(LANES - 1)) || last);
      row_last_c     = accept && last;
   end

   // Lane counter and partial-row register; both restart once a row is handed off.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         lane_q <= '0;
         pack_q <= '0;
      end else if (accept) begin
         if (row_complete_c) begin
            lane_q <= '0;
            pack_q <= '0;
         end else begin
            lane_q <= lane_q + LANE_W'(1);
            pack_q <= row_data_c;
         end
      end
   end

endmodule

// File: rtl/bram0_stream_loader.sv
// Loads a byte stream into BRAM0 as packed rows, then kicks the accessor and waits for it.
module bram0_stream_loader
   import bram0_stream_loader_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_start_i,
   bram0_stream_loader_if.slave strm,
   output logic [AWIDTH-1:0]    addr_b0_o,
   output logic                 ce_b0_o,
   output logic                 we_b0_o,
   output logic [DWIDTH-1:0]    d_b0_o,
   output logic                 start_run_o,
   output logic [CNT_BIT-1:0]   run_count_o,
   input  logic                 acc_done_i,
   output logic                 idle_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 overflow_o
);

   localparam int unsigned      PTR_W    = AWIDTH + 1;
   localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(MEM_SIZE - 1);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   logic [PTR_W-1:0]   row_ptr_q;
   logic [PTR_W-1:0]   row_ptr_d;
   logic               end_pend_q;
   logic               end_pend_d;
   logic               ready_q;
   logic               ready_d;
   logic               wr_d;
   logic [AWIDTH-1:0]  addr_d;
   logic [DWIDTH-1:0]  data_d;
   logic               start_d;
   logic [CNT_BIT-1:0] run_count_d;
   logic               overflow_d;
   logic               idle_d;
   logic               busy_d;
   logic               done_d;
   logic               clear_c;
   logic               accept_c;
   logic               row_complete_c;
   logic               row_last_c;
   logic [DWIDTH-1:0]  row_data_c;

   assign accept_c       = strm.s_valid_i && ready_q;
   assign strm.s_ready_o = ready_q;

   bram0_stream_loader_stream_packer u_packer (
      .clk            (clk),
      .reset          (reset),
      .clear          (clear_c),
      .accept         (accept_c),
      .data           (strm.s_data_i),
      .last           (strm.s_last_i),
      .row_complete_c (row_complete_c),
      .row_last_c     (row_last_c),
      .row_data_c     (row_data_c)
   );

   // Next-state, row write scheduling and output decode.
   always_comb begin
      state_d     = state_q;
      row_ptr_d   = row_ptr_q;
      end_pend_d  = end_pend_q;
      ready_d     = 1'b0;
      wr_d        = 1'b0;
      addr_d      = addr_b0_o;
      data_d      = d_b0_o;
      start_d     = 1'b0;
      run_count_d = run_count_o;
      overflow_d  = overflow_o;
      clear_c     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (load_start_i) begin
               state_d     = S_FILL;
               row_ptr_d   = '0;
               end_pend_d  = 1'b0;
               run_count_d = '0;
               overflow_d  = 1'b0;
               clear_c     = 1'b1;
               ready_d     = 1'b1;
            end
         end
         S_FILL: begin
            if (end_pend_q) begin
               // Final row is being written this cycle; the pointer already counts it.
               state_d     = S_KICK;
               start_d     = 1'b1;
               run_count_d = CNT_BIT'(row_ptr_q);
               end_pend_d  = 1'b0;
            end else begin
               ready_d = 1'b1;
               if (row_complete_c) begin
                  wr_d      = 1'b1;
                  addr_d    = row_ptr_q[AWIDTH-1:0];
                  data_d    = row_data_c;
                  row_ptr_d = row_ptr_q + PTR_W'(1);
                  if (row_last_c || (row_ptr_q == LAST_ROW)) begin
                     ready_d    = 1'b0;
                     end_pend_d = 1'b1;
                     if (!row_last_c) begin
                        overflow_d = 1'b1;
                     end
                  end
               end
            end
         end
         S_KICK: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (acc_done_i) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      idle_d = (state_d == S_IDLE);
      busy_d = (state_d == S_FILL) || (state_d == S_KICK) || (state_d == S_WAIT);
      done_d = (state_d == S_DONE);
   end

   // State, pointer and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         row_ptr_q   <= '0;
         end_pend_q  <= 1'b0;
         ready_q     <= 1'b0;
         addr_b0_o   <= '0;
         ce_b0_o     <= 1'b0;
         we_b0_o     <= 1'b0;
         d_b0_o      <= '0;
         start_run_o <= 1'b0;
         run_count_o <= '0;
         overflow_o  <= 1'b0;
         idle_o      <= 1'b1;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_ptr_q   <= row_ptr_d;
         end_pend_q  <= end_pend_d;
         ready_q     <= ready_d;
         addr_b0_o   <= addr_d;
         ce_b0_o     <= wr_d;
         we_b0_o     <= wr_d;
         d_b0_o      <= data_d;
         start_run_o <= start_d;
         run_count_o <= run_count_d;
         overflow_o  <= overflow_d;
         idle_o      <= idle_d;
         busy_o      <= busy_d;
         done_o      <= done_d;
      end
   end

endmodule

// File: tb/tb_bram0_stream_loader.sv
// Directed bench for bram0_stream_loader: frame table, overflow, wait-state and reset sequences.
module tb_bram0_stream_loader;
   import bram0_stream_loader_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic               load_start_i;
   logic               acc_done_i;
   logic [AWIDTH-1:0]  addr_b0_o;
   logic               ce_b0_o;
   logic               we_b0_o;
   logic [DWIDTH-1:0]  d_b0_o;
   logic               start_run_o;
   logic [CNT_BIT-1:0] run_count_o;
   logic               idle_o;
   logic               busy_o;
   logic               done_o;
   logic               overflow_o;

   bram0_stream_loader_if sif ();

   bram0_stream_loader dut (
      .clk          (clk),
      .reset        (reset),
      .load_start_i (load_start_i),
      .strm         (sif),
      .addr_b0_o    (addr_b0_o),
      .ce_b0_o      (ce_b0_o),
      .we_b0_o      (we_b0_o),
      .d_b0_o       (d_b0_o),
      .start_run_o  (start_run_o),
      .run_count_o  (run_count_o),
      .acc_done_i   (acc_done_i),
      .idle_o       (idle_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .overflow_o   (overflow_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned       n;
      logic [7:0]        first;
      bit                gaps;
      int unsigned       exp_rows;
      logic [2:0][31:0]  exp_row;
   } vec_t;

   vec_t vecs [6];

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   logic [AWIDTH-1:0] wr_addr_q [$];
   logic [DWIDTH-1:0] wr_data_q [$];
   int unsigned       n_start   = 0;
   int unsigned       ce_we_bad = 0;

   // Passive monitor: logs every BRAM0 write and every accessor kick.
   always @(negedge clk) begin
      if (we_b0_o) begin
         wr_addr_q.push_back(addr_b0_o);
         wr_data_q.push_back(d_b0_o);
      end
      if (start_run_o) n_start <= n_start + 1;
      if (ce_b0_o !== we_b0_o) ce_we_bad <= ce_we_bad + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // All stimulus tasks are entered and left on a falling edge.
   task automatic do_load();
      load_start_i = 1'b1;
      @(negedge clk);
      load_start_i = 1'b0;
   endtask

   task automatic drive_frame(input int unsigned n, input logic [7:0] first, input bit gaps,
                              input bit last_en, output int unsigned bubbles);
      int unsigned idx = 0;
      int unsigned cyc = 0;
      bit          v;
      bubbles = 0;
      while (idx < n && cyc < 2000) begin
         v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         sif.s_valid_i = v;
         sif.s_data_i  = first + 8'(idx);
         sif.s_last_i  = last_en && (idx == n - 1);
         if (v && sif.s_ready_o) idx++;
         else if (v) bubbles++;
         @(negedge clk);
         cyc++;
      end
      sif.s_valid_i = 1'b0;
      sif.s_last_i  = 1'b0;
      if (idx < n) chk("frame_accept_timeout", 64'(idx), 64'(n));
   endtask

   task automatic wait_start(input int unsigned base);
      int unsigned c = 0;
      while (n_start == base && c < 40) begin
         @(negedge clk);
         c++;
      end
   endtask

   // In S_WAIT: stray load/data must be ignored, then acc_done completes the run.
   task automatic finish_run(input string tag);
      int                 wb;
      logic [CNT_BIT-1:0] rc;
      wb = wr_addr_q.size();
      rc = run_count_o;
      load_start_i  = 1'b1;
      sif.s_valid_i = 1'b1;
      sif.s_data_i  = 8'hEE;
      sif.s_last_i  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk({tag, "_wait_ready"}, 64'(sif.s_ready_o), 64'(0));
      end
      load_start_i  = 1'b0;
      sif.s_valid_i = 1'b0;
      sif.s_last_i  = 1'b0;
      chk({tag, "_wait_busy"}, 64'(busy_o), 64'(1));
      chk({tag, "_wait_no_write"}, 64'(wr_addr_q.size()), 64'(wb));
      acc_done_i = 1'b1;
      @(negedge clk);
      acc_done_i = 1'b0;
      chk({tag, "_done_flag"}, 64'({idle_o, busy_o, done_o}), 64'(3'b001));
      @(negedge clk);
      chk({tag, "_idle_flag"}, 64'({idle_o, busy_o, done_o}), 64'(3'b100));
      chk({tag, "_count_stable"}, 64'(run_count_o), 64'(rc));
   endtask

   initial begin
      int unsigned bubbles;
      int          wb;
      int unsigned sb;
      int unsigned acc;
      int unsigned cyc;
      int unsigned bad;
      logic [31:0] exp_d;
      bit          rdy;

      vecs[0] = '{8,  8'h01, 1'b0, 2, {32'h0,        32'h08070605, 32'h04030201}};
      vecs[1] = '{5,  8'hA0, 1'b0, 2, {32'h0,        32'h000000A4, 32'hA3A2A1A0}};
      vecs[2] = '{12, 8'h10, 1'b0, 3, {32'h1B1A1918, 32'h17161514, 32'h13121110}};
      vecs[3] = '{12, 8'h10, 1'b1, 3, {32'h1B1A1918, 32'h17161514, 32'h13121110}};
      vecs[4] = '{1,  8'h55, 1'b0, 1, {32'h0,        32'h0,        32'h00000055}};
      vecs[5] = '{7,  8'hC0, 1'b1, 2, {32'h0,        32'h00C6C5C4, 32'hC3C2C1C0}};

      reset         = 1'b1;
      load_start_i  = 1'b0;
      acc_done_i    = 1'b0;
      sif.s_valid_i = 1'b0;
      sif.s_data_i  = '0;
      sif.s_last_i  = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_flags", 64'({idle_o, busy_o, done_o}), 64'(3'b100));
      chk("rst_bram", 64'({ce_b0_o, we_b0_o, addr_b0_o}), 64'(0));
      chk("rst_data", 64'(d_b0_o), 64'(0));
      chk("rst_misc", 64'({sif.s_ready_o, start_run_o, overflow_o}), 64'(0));
      chk("rst_count", 64'(run_count_o), 64'(0));
      reset = 1'b0;

      // acc_done and stream data in S_IDLE are ignored.
      acc_done_i    = 1'b1;
      sif.s_valid_i = 1'b1;
      @(negedge clk);
      acc_done_i    = 1'b0;
      sif.s_valid_i = 1'b0;
      chk("idle_ignore_done", 64'({idle_o, done_o, sif.s_ready_o}), 64'(3'b100));

      for (int i = 0; i < 6; i++) begin
         wb = wr_addr_q.size();
         sb = n_start;
         do_load();
         chk($sformatf("vec%0d_fill_ready", i), 64'({sif.s_ready_o, busy_o}), 64'(2'b11));
         drive_frame(vecs[i].n, vecs[i].first, vecs[i].gaps, 1'b1, bubbles);
         wait_start(sb);
         chk($sformatf("vec%0d_rows", i), 64'(wr_addr_q.size() - wb), 64'(vecs[i].exp_rows));
         for (int k = 0; k < int'(vecs[i].exp_rows); k++) begin
            chk($sformatf("vec%0d_addr%0d", i, k),
                (wb + k < wr_addr_q.size()) ? 64'(wr_addr_q[wb + k]) : {64{1'bx}}, 64'(k));
            chk($sformatf("vec%0d_data%0d", i, k),
                (wb + k < wr_data_q.size()) ? 64'(wr_data_q[wb + k]) : {64{1'bx}},
                64'(vecs[i].exp_row[k]));
         end
         chk($sformatf("vec%0d_run_count", i), 64'(run_count_o), 64'(vecs[i].exp_rows));
         chk($sformatf("vec%0d_starts", i), 64'(n_start - sb), 64'(1));
         if (!vecs[i].gaps) chk($sformatf("vec%0d_bubbles", i), 64'(bubbles), 64'(0));
         finish_run($sformatf("vec%0d", i));
      end

      // 1028 bytes with no last: BRAM fills at 256 rows and the tail is refused.
      wb = wr_addr_q.size();
      sb = n_start;
      do_load();
      acc = 0;
      cyc = 0;
      while (acc < 1028 && cyc < 1100) begin
         sif.s_valid_i = 1'b1;
         sif.s_data_i  = 8'(acc);
         sif.s_last_i  = 1'b0;
         rdy = sif.s_ready_o;
         @(negedge clk);
         if (rdy) acc++;
         cyc++;
      end
      chk("ovf_accepted", 64'(acc), 64'(1024));
      chk("ovf_ready_low", 64'(sif.s_ready_o), 64'(0));
      sif.s_valid_i = 1'b0;
      chk("ovf_rows", 64'(wr_addr_q.size() - wb), 64'(256));
      bad = 0;
      for (int k = 0; k < 256; k++) begin
         exp_d = {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)};
         if (wb + k >= wr_addr_q.size()) bad++;
         else if (wr_addr_q[wb + k] !== AWIDTH'(k) || wr_data_q[wb + k] !== exp_d) bad++;
      end
      chk("ovf_row_content", 64'(bad), 64'(0));
      chk("ovf_flag", 64'(overflow_o), 64'(1));
      chk("ovf_run_count", 64'(run_count_o), 64'(256));
      chk("ovf_starts", 64'(n_start - sb), 64'(1));
      finish_run("ovf");
      chk("ovf_sticky", 64'(overflow_o), 64'(1));

      // Reset right after the 3rd byte: partial row dropped, no kick.
      wb = wr_addr_q.size();
      sb = n_start;
      do_load();
      chk("load_clears_ovf", 64'({overflow_o, run_count_o}), 64'(0));
      drive_frame(3, 8'h30, 1'b0, 1'b0, bubbles);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_flags", 64'({idle_o, busy_o, done_o, sif.s_ready_o}), 64'(4'b1000));
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_mid_no_write", 64'(wr_addr_q.size()), 64'(wb));
      chk("rst_mid_no_start", 64'(n_start), 64'(sb));
      chk("rst_mid_idle", 64'(idle_o), 64'(1));

      chk("ce_matches_we", 64'(ce_we_bad), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bram0_stream_loader.md
Name: bram0_stream_loader

Overview:
- Upstream stage of the BRAM accumulate datapath.
- Accepts a byte stream over a valid/ready handshake and packs 4 bytes per 32-bit row.
- Writes the rows sequentially into BRAM0 from address 0, then pulses start_run_o with the row count to the BRAM accessor.
- Holds busy until the accessor reports done, so BRAM0 is never overwritten mid-run.

Parameters:
DWIDTH, 32, BRAM0 row width
IN_DATA_WIDTH, 8, stream element width; LANES = DWIDTH/IN_DATA_WIDTH = 4
AWIDTH, 8, BRAM0 address width
MEM_SIZE, 256, BRAM0 depth in rows
CNT_BIT, 31, width of run_count_o

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
load_start_i  in  1  pulse: begin a new load; honoured only in S_IDLE
s_valid_i  in  1  stream element valid
s_data_i  in  IN_DATA_WIDTH  stream element
s_last_i  in  1  marks final element of frame; qualified by s_valid_i
s_ready_o  out  1  loader can accept an element
addr_b0_o  out  AWIDTH  BRAM0 write address
ce_b0_o  out  1  BRAM0 chip enable
we_b0_o  out  1  BRAM0 write enable
d_b0_o  out  DWIDTH  BRAM0 write data
start_run_o  out  1  one-cycle pulse to accessor
run_count_o  out  CNT_BIT  rows written; stable from start_run_o until the next load_start_i
acc_done_i  in  1  accessor done pulse
idle_o, busy_o, done_o  out  1 each  state flags, one-hot
overflow_o  out  1  sticky: frame exceeded MEM_SIZE rows; cleared by load_start_i

Behaviour:
- Reset values: all outputs 0 except idle_o=1. State S_IDLE, lane=0, row pointer=0, pack register=0.
- States: S_IDLE, S_FILL, S_KICK, S_WAIT, S_DONE.
- S_IDLE: s_ready_o=0. load_start_i moves to S_FILL and clears the row pointer, lane, run_count_o and overflow_o.
- S_FILL: s_ready_o=1 unless the write-pending flag blocks (see full row below).
  - Accept an element when s_valid_i && s_ready_o.
  - Element k of the row goes to bits [8k+7:8k]. The first element lands in lane 0, matching the accessor's core slicing.
- Row complete when lane 3 is accepted, or s_last_i is accepted on any lane.
  - Unused lanes of a partial row are zero.
  - Next cycle: ce_b0_o=we_b0_o=1 for exactly one cycle, addr_b0_o = row pointer, d_b0_o = packed row (registered, 1-cycle write latency).
  - The row pointer then increments and lane resets to 0.
  - Back-to-back full-rate streaming is supported: the write stage and packing overlap with no bubble.
- Frame end: after the write of the row containing s_last_i, go to S_KICK and set run_count_o = rows written.
- Full BRAM: after row MEM_SIZE-1 is written without s_last_i:
  - s_ready_o drops, overflow_o=1.
  - run_count_o = MEM_SIZE, go to S_KICK.
  - Remaining elements are left unaccepted upstream.
  - The pointer never wraps.
- S_KICK: start_run_o=1 for one cycle, then S_WAIT.
- S_WAIT: busy_o=1, s_ready_o=0. On acc_done_i go to S_DONE.
- S_DONE: done_o=1 for one cycle, then S_IDLE.
- busy_o=1 in S_FILL, S_KICK and S_WAIT.
- load_start_i outside S_IDLE is ignored.
- acc_done_i outside S_WAIT is ignored.
- s_valid_i with s_ready_o=0 is not consumed; data must be held by the source.
- Reset asserted mid-operation: return to reset values the next edge. Any pending write is dropped and no start_run_o is issued.

Decomposition:
- Shared package holds: state encoding (S_IDLE..S_DONE), LANES, and the BRAM geometry constants (DWIDTH, AWIDTH, MEM_SIZE) shared with the accessor.
- One natural sub-module, stream_packer: lane counter, pack register and row-complete strobe.
- The FSM, row pointer and BRAM0 interface stay in the top.

Test Plan:
- 8 bytes 0x01..0x08 at full rate, last on 0x08:
  - Writes addr0=0x04030201 and addr1=0x08070605.
  - start_run_o pulses once with run_count_o=2.
  - No ready bubbles.
- 5 bytes 0xA0..0xA4, last on 0xA4:
  - Writes addr0=0xA3A2A1A0 and addr1=0x000000A4.
  - run_count_o=2.
- Random s_valid_i gaps on a 12-byte frame: written rows identical to the gap-free case. Data held while not ready is never duplicated.
- 1028 bytes with no last (MEM_SIZE=256):
  - 256 writes at addr 0..255.
  - overflow_o=1, run_count_o=256.
  - s_ready_o=0 after the 1024th byte; no write to addr 0 again.
- In S_WAIT:
  - A second load_start_i and stream data are ignored (s_ready_o=0).
  - acc_done_i gives done_o=1 for one cycle, then idle_o=1.
- Reset asserted on the cycle after the 3rd byte of a frame: no BRAM write and no start_run_o; idle_o=1 after the next edge.
